// File: rtl/uart_word_tx.sv
// Word-level 8N1 UART transmitter: each accepted word goes out as WORD_BYTES frames, byte 0 first.
// Define UART_TX_PARITY_EN to insert an even-parity bit after each data byte (11-bit frames).
//
// state  | meaning
// IDLE   | line high, s_ready asserted, waiting for a word
// START  | start bit (low) for one bit period
// DATA   | 8 data bits, LSB first, one bit period each
// PARITY | even parity of the data byte (UART_TX_PARITY_EN only)
// STOP   | stop bit (high), then next byte's START or IDLE
module uart_word_tx #(
    parameter int WORD_BYTES = 4,
    parameter int PRESCALE_W = 16
) (
    input  logic                    clk,
    input  logic                    reset_l,
    input  logic [8*WORD_BYTES-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [PRESCALE_W-1:0]   prescale,
    output logic                    tx,
    output logic                    busy
);

    // prescale*8 needs three bits more than prescale itself
    localparam int TIMER_W = PRESCALE_W + 3;
    localparam int BYTE_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(WORD_BYTES - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                  state;
    logic [8*WORD_BYTES-1:0] wordQ;
    logic [PRESCALE_W-1:0]   prescaleQ;
    logic [TIMER_W-1:0]      bitTimer;
    logic [TIMER_W-1:0]      bitLast;
    logic [2:0]              bitCnt;
    logic [BYTE_W-1:0]       byteCnt;
    logic [7:0]              curByte;
    logic                    bitEnd;

    assign curByte = wordQ[7:0];
    assign bitLast = {prescaleQ, 3'b000} - TIMER_W'(1);
    assign bitEnd  = (bitTimer == bitLast);

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state     <= IDLE;
            tx        <= 1'b1;
            busy      <= 1'b0;
            s_ready   <= 1'b0;
            bitTimer  <= '0;
            bitCnt    <= '0;
            byteCnt   <= '0;
            wordQ     <= '0;
            prescaleQ <= '0;
        end else begin
            bitTimer <= bitEnd ? '0 : bitTimer + TIMER_W'(1);
            case (state)
                IDLE: begin
                    bitTimer <= '0;
                    if (s_valid && s_ready) begin
                        wordQ     <= s_data;
                        prescaleQ <= (prescale == '0) ? PRESCALE_W'(1) : prescale;
                        state     <= START;
                        tx        <= 1'b0;
                        busy      <= 1'b1;
                        s_ready   <= 1'b0;
                        bitCnt    <= '0;
                        byteCnt   <= '0;
                    end else begin
                        tx      <= 1'b1;
                        busy    <= 1'b0;
                        s_ready <= 1'b1;
                    end
                end
                START: begin
                    if (bitEnd) begin
                        state  <= DATA;
                        tx     <= curByte[0];
                        bitCnt <= '0;
                    end
                end
                DATA: begin
                    if (bitEnd) begin
                        if (bitCnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= ^curByte;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bitCnt <= bitCnt + 3'd1;
                            tx     <= curByte[bitCnt + 3'd1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bitEnd) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bitEnd) begin
                        // last stop bit ends straight into IDLE so a held word is taken next cycle
                        if (byteCnt == LAST_BYTE) begin
                            state   <= IDLE;
                            tx      <= 1'b1;
                            busy    <= 1'b0;
                            s_ready <= 1'b1;
                        end else begin
                            state   <= START;
                            tx      <= 1'b0;
                            byteCnt <= byteCnt + BYTE_W'(1);
                            bitCnt  <= '0;
                            wordQ   <= wordQ >> 8;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    busy    <= 1'b0;
                    s_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
